// File: rtl/fp_unpack_prenorm_if.sv
// fp_unpack_prenorm_if: operand-in / unpacked-result-out valid/ready bundle for fp_unpack_prenorm
interface fp_unpack_prenorm_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] fa;
    logic        db;
    logic        out_valid;
    logic        out_ready;
    logic        sa;
    logic [12:0] ea;
    logic [52:0] fa_n;
    logic [5:0]  lz;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        denorm;
    logic        db_o;
    modport master (
        output in_valid, fa, db, out_ready,
        input  in_ready, out_valid, sa, ea, fa_n, lz, zero, inf, nan, snan, denorm, db_o
    );
    modport slave (
        input  in_valid, fa, db, out_ready,
        output in_ready, out_valid, sa, ea, fa_n, lz, zero, inf, nan, snan, denorm, db_o
    );
endinterface

// File: rtl/fp_unpack_prenorm.sv
// fp_unpack_prenorm: 2-stage valid/ready unpacker of IEEE double/single operands into
// sign, 13-bit unbiased exponent and pre-normalized 1.52 significand with class flags.
module fp_unpack_prenorm (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_unpack_prenorm_if.slave   io
);
    logic        s1_v, s2_v, s1_load, s2_load;
    logic [10:0] exp_c;
    logic [51:0] frac_c;
    logic [52:0] man_c;
    logic        emax_c;
    logic [5:0]  lz_c;
    logic [4:0]  cls_c;
    logic        s1_sa, s1_db;
    logic [10:0] s1_exp;
    logic [52:0] s1_man;
    logic [5:0]  s1_lz;
    logic [4:0]  s1_cls;
    logic [12:0] ea_c;
    logic        s2_sa, s2_db;
    logic [12:0] s2_ea;
    logic [52:0] s2_man;
    logic [5:0]  s2_lz;
    logic [4:0]  s2_cls;

    assign s2_load     = !s2_v || io.out_ready;
    assign s1_load     = !s1_v || s2_load;
    assign io.in_ready = s1_load;

    // single fraction sits left-aligned so its hidden bit lines up at 52 like a double
    always_comb begin
        exp_c  = io.db ? io.fa[62:52] : {3'b000, io.fa[62:55]};
        frac_c = io.db ? io.fa[51:0] : {io.fa[54:32], 29'b0};
        man_c  = {|exp_c, frac_c};
        emax_c = io.db ? &io.fa[62:52] : &io.fa[62:55];
        lz_c   = '0;
        for (int i = 0; i < 53; i++)
            if (man_c[i]) lz_c = 6'(52 - i);
        cls_c  = {exp_c == '0 && frac_c == '0,
                  emax_c && frac_c == '0,
                  emax_c && frac_c != '0,
                  emax_c && frac_c != '0 && !frac_c[51],
                  exp_c == '0 && frac_c != '0};
    end

    // cls = {zero, inf, nan, snan, denorm}; denormal emin is -1022 (0x1C02) or -126 (0x1F82)
    always_comb begin
        ea_c = s1_cls[4] ? 13'd0 :
               s1_cls[0] ? (s1_db ? 13'h1C02 : 13'h1F82) - {7'b0, s1_lz} :
               {2'b00, s1_exp} - (s1_db ? 13'd1023 : 13'd127);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_sa  <= 1'b0;
            s1_db  <= 1'b0;
            s1_exp <= '0;
            s1_man <= '0;
            s1_lz  <= '0;
            s1_cls <= '0;
        end else if (s1_load) begin
            s1_v <= io.in_valid;
            if (io.in_valid) begin
                s1_sa  <= io.fa[63];
                s1_db  <= io.db;
                s1_exp <= exp_c;
                s1_man <= man_c;
                s1_lz  <= lz_c;
                s1_cls <= cls_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v   <= 1'b0;
            s2_sa  <= 1'b0;
            s2_db  <= 1'b0;
            s2_ea  <= '0;
            s2_man <= '0;
            s2_lz  <= '0;
            s2_cls <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_sa  <= s1_sa;
                s2_db  <= s1_db;
                s2_ea  <= ea_c;
                s2_man <= s1_man << s1_lz;
                s2_lz  <= s1_lz;
                s2_cls <= s1_cls;
            end
        end
    end

    assign io.out_valid = s2_v;
    assign io.sa        = s2_sa;
    assign io.ea        = s2_ea;
    assign io.fa_n      = s2_man;
    assign io.lz        = s2_lz;
    assign io.zero      = s2_cls[4];
    assign io.inf       = s2_cls[3];
    assign io.nan       = s2_cls[2];
    assign io.snan      = s2_cls[1];
    assign io.denorm    = s2_cls[0];
    assign io.db_o      = s2_db;
endmodule

// File: tb/tb_fp_unpack_prenorm.sv
// tb_fp_unpack_prenorm: table-driven check of fp_unpack_prenorm plus stall and reset sequences.
module tb_fp_unpack_prenorm;
    typedef struct {
        logic [63:0] fa;
        logic        db;
        logic        sa;
        logic [12:0] ea;
        logic [52:0] fa_n;
        logic [5:0]  lz;
        logic [4:0]  cls;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t v[14];

    fp_unpack_prenorm_if io ();
    fp_unpack_prenorm dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int i, input string tag);
        check($sformatf("%s[%0d].sa", tag, i), 64'(io.sa), 64'(v[i].sa));
        check($sformatf("%s[%0d].ea", tag, i), 64'(io.ea), 64'(v[i].ea));
        check($sformatf("%s[%0d].fa_n", tag, i), 64'(io.fa_n), 64'(v[i].fa_n));
        check($sformatf("%s[%0d].lz", tag, i), 64'(io.lz), 64'(v[i].lz));
        check($sformatf("%s[%0d].cls", tag, i), 64'({io.zero, io.inf, io.nan, io.snan, io.denorm}), 64'(v[i].cls));
        check($sformatf("%s[%0d].db_o", tag, i), 64'(io.db_o), 64'(v[i].db));
    endtask

    task automatic drive(input int i, input logic valid);
        io.in_valid = valid;
        io.fa       = v[i].fa;
        io.db       = v[i].db;
    endtask

    initial begin
        int  k, got, first, last;
        logic acc;
        // cls = {zero, inf, nan, snan, denorm}
        v[0]  = '{64'h3FF0_0000_0000_0000, 1'b1, 1'b0, 13'h0000, 53'h10_0000_0000_0000, 6'd0,  5'b00000};
        v[1]  = '{64'h0000_0000_0000_0001, 1'b1, 1'b0, 13'h1BCE, 53'h10_0000_0000_0000, 6'd52, 5'b00001};
        v[2]  = '{64'h0000_0001_DEAD_BEEF, 1'b0, 1'b0, 13'h1F6B, 53'h10_0000_0000_0000, 6'd23, 5'b00001};
        v[3]  = '{64'h3FC0_0000_0000_0000, 1'b0, 1'b0, 13'h0000, 53'h18_0000_0000_0000, 6'd0,  5'b00000};
        v[4]  = '{64'h7FF4_0000_0000_0000, 1'b1, 1'b0, 13'h0400, 53'h14_0000_0000_0000, 6'd0,  5'b00110};
        v[5]  = '{64'hFFF0_0000_0000_0000, 1'b1, 1'b1, 13'h0400, 53'h10_0000_0000_0000, 6'd0,  5'b01000};
        v[6]  = '{64'h0000_0000_0000_0000, 1'b1, 1'b0, 13'h0000, 53'h00_0000_0000_0000, 6'd0,  5'b10000};
        v[7]  = '{64'hFFC0_0000_0000_0000, 1'b0, 1'b1, 13'h0080, 53'h18_0000_0000_0000, 6'd0,  5'b00100};
        v[8]  = '{64'h8000_0000_0000_0000, 1'b1, 1'b1, 13'h0000, 53'h00_0000_0000_0000, 6'd0,  5'b10000};
        v[9]  = '{64'h0040_0000_0000_0000, 1'b0, 1'b0, 13'h1F81, 53'h10_0000_0000_0000, 6'd1,  5'b00001};
        v[10] = '{64'h000F_FFFF_FFFF_FFFF, 1'b1, 1'b0, 13'h1C01, 53'h1F_FFFF_FFFF_FFFE, 6'd1,  5'b00001};
        v[11] = '{64'h7FEF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 13'h03FF, 53'h1F_FFFF_FFFF_FFFF, 6'd0,  5'b00000};
        v[12] = '{64'h7F80_0000_0000_0000, 1'b0, 1'b0, 13'h0080, 53'h10_0000_0000_0000, 6'd0,  5'b01000};
        v[13] = '{64'h7F80_0001_0000_0000, 1'b0, 1'b0, 13'h0080, 53'h10_0000_2000_0000, 6'd0,  5'b00110};

        drive(0, 1'b0);
        io.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 64'(io.out_valid), 64'd0);
        check("reset.in_ready", 64'(io.in_ready), 64'd1);
        check("reset.ea", 64'(io.ea), 64'd0);
        check("reset.fa_n", 64'(io.fa_n), 64'd0);
        check("reset.flags", 64'({io.sa, io.zero, io.inf, io.nan, io.snan, io.denorm, io.db_o}), 64'd0);
        rst_n = 1'b1;
        io.out_ready = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(i, 1'b1);
            #1 check($sformatf("vec[%0d].in_ready", i), 64'(io.in_ready), 64'd1);
            @(posedge clk); #1;
            io.in_valid = 1'b0;
            check($sformatf("vec[%0d].lat1_valid", i), 64'(io.out_valid), 64'd0);
            @(posedge clk); #1;
            check($sformatf("vec[%0d].lat2_valid", i), 64'(io.out_valid), 64'd1);
            check_out(i, "vec");
        end
        @(posedge clk); #1;

        // stall: out_ready low while four operands are offered back to back
        io.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            drive(k < 4 ? k : 0, k < 4);
            #1 acc = io.in_valid && io.in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            if (c >= 2) begin
                check($sformatf("stall[%0d].out_valid", c), 64'(io.out_valid), 64'd1);
                check($sformatf("stall[%0d].hold_fa_n", c), 64'(io.fa_n), 64'(v[0].fa_n));
                check($sformatf("stall[%0d].hold_ea", c), 64'(io.ea), 64'(v[0].ea));
            end
        end
        check("stall.accepted", 64'(k), 64'd2);
        drive(k, 1'b1);
        #1 check("stall.in_ready", 64'(io.in_ready), 64'd0);
        io.out_ready = 1'b1;
        got = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            drive(k < 4 ? k : 0, k < 4);
            #1 acc = io.in_valid && io.in_ready;
            if (io.out_valid) begin
                check_out(got, "drain");
                if (first < 0) first = c;
                last = c;
                got++;
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        io.in_valid = 1'b0;
        check("drain.count", 64'(got), 64'd4);
        check("drain.accepted", 64'(k), 64'd4);
        check("drain.span", 64'(last - first), 64'd3);
        #1 check("drain.no_dup", 64'(io.out_valid), 64'd0);

        // reset with both stages full
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(4 + c, 1'b1);
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        check("full.out_valid", 64'(io.out_valid), 64'd1);
        check("full.in_ready", 64'(io.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 64'(io.out_valid), 64'd0);
        check("arst.in_ready", 64'(io.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        drive(9, 1'b1);
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        check("post_rst.lat1_valid", 64'(io.out_valid), 64'd0);
        @(posedge clk); #1;
        check("post_rst.lat2_valid", 64'(io.out_valid), 64'd1);
        check_out(9, "post_rst");
        @(posedge clk); #1;
        check("post_rst.no_replay", 64'(io.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
